// File: rtl/alpaca_types_streaming_packed_pkg.sv
// Shared types for the packed complex sample stream: sample width, lanes per
// beat, the complex sample struct and the frame-checker enums and helpers.
package alpaca_types_streaming_packed_pkg;

    localparam int WIDTH        = 16;
    localparam int SAMP_PER_CLK = 4;
    localparam int CNT_W        = 16;

    // Complex sample; re occupies the upper half of the lane.
    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cx_t;

    // One beat: lane j is element [j], i.e. bits [j*2*WIDTH +: 2*WIDTH].
    typedef cx_t [SAMP_PER_CLK-1:0] pkt_stream_packed_t;

    typedef enum logic {
        RAMP    = 1'b0,
        IMPULSE = 1'b1
    } check_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Add and clamp at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Number of set flags in a per-lane mismatch vector.
    function automatic logic [CNT_W-1:0] popcnt(input logic [SAMP_PER_CLK-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < SAMP_PER_CLK; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/axis_ready_throttle.sv
// Backpressure generator: while run is high, tready drops for one cycle in
// every READY_PERIOD cycles. READY_PERIOD of 0 keeps tready high in run.
module axis_ready_throttle #(
    parameter int READY_PERIOD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tready
);

    localparam int CNT_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((READY_PERIOD > 0) ? READY_PERIOD - 1 : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Free-running phase counter, held at zero outside run so each run starts ready.
    always_comb begin
        cnt_d = '0;
        if (run && (READY_PERIOD > 0)) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Ready depends only on the phase counter, never on the source's valid.
    assign tready = run && ((READY_PERIOD == 0) || (cnt_q != LAST));

endmodule

// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that checks every lane of every accepted beat against a
// ramp or impulse pattern, checks tlast placement, counts frames and errors,
// and throttles tready to exercise the source's backpressure handling.
module axis_frame_checker
    import alpaca_types_streaming_packed_pkg::*;
#(
    parameter int          FFT_LEN      = 16,
    parameter check_mode_t CHECK_MODE   = RAMP,
    parameter int          IMPULSE_PHA  = 0,
    parameter int          IMPULSE_VAL  = 1,
    parameter int          NUM_FRAMES   = 4,
    parameter int          READY_PERIOD = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [SAMP_PER_CLK*2*WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [15:0]                     frame_cnt,
    output logic [15:0]                     samp_err_cnt,
    output logic [15:0]                     last_err_cnt
);

    localparam int FRAME_BEATS = FFT_LEN / SAMP_PER_CLK;
    localparam int BEAT_W      = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int FR_W        = $clog2(NUM_FRAMES + 1);

    chk_state_t              state_q,        state_d;
    logic [BEAT_W-1:0]       beat_q,         beat_d;
    logic [FR_W-1:0]         frames_q,       frames_d;
    logic                    pipe_valid_q,   pipe_valid_d;
    logic [SAMP_PER_CLK-1:0] mism_q,         mism_d;
    logic                    last_bad_q,     last_bad_d;
    logic                    frame_end_q,    frame_end_d;
    logic [15:0]             frame_cnt_q,    frame_cnt_d;
    logic [15:0]             samp_err_cnt_q, samp_err_cnt_d;
    logic [15:0]             last_err_cnt_q, last_err_cnt_d;
    logic                    err_q,          err_d;

    logic                    run;
    logic                    tready;
    logic                    xfer;
    logic                    exp_last;
    logic [SAMP_PER_CLK-1:0] lane_mism;

    assign run = (state_q == RUN);

    axis_ready_throttle #(
        .READY_PERIOD(READY_PERIOD)
    ) u_throttle (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .tready (tready)
    );

    assign xfer     = s_axis_tvalid & tready;
    assign exp_last = (beat_q == BEAT_W'(FRAME_BEATS - 1));

    // Per-lane pattern compare against sample index k = beat*SAMP_PER_CLK + lane.
    for (genvar gi = 0; gi < SAMP_PER_CLK; gi++) begin : g_lane
        cx_t                     lane_s;
        logic [15:0]             k_idx;
        logic signed [WIDTH-1:0] exp_re;

        assign lane_s = s_axis_tdata[gi*2*WIDTH +: 2*WIDTH];
        assign k_idx  = 16'(beat_q) * 16'(SAMP_PER_CLK) + 16'(gi);

        // Expected real part for this lane in the selected pattern.
        always_comb begin
            exp_re = '0;
            if (CHECK_MODE == RAMP) begin
                exp_re = WIDTH'(k_idx);
            end else if (k_idx == 16'(IMPULSE_PHA)) begin
                exp_re = WIDTH'(IMPULSE_VAL);
            end
        end

        assign lane_mism[gi] = (lane_s.re != exp_re) || (lane_s.im != '0);
    end

    // Next-state logic: stage-2 counter update, then the run/frame state machine.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        frames_d       = frames_q;
        pipe_valid_d   = 1'b0;
        mism_d         = mism_q;
        last_bad_d     = last_bad_q;
        frame_end_d    = frame_end_q;
        frame_cnt_d    = frame_cnt_q;
        samp_err_cnt_d = samp_err_cnt_q;
        last_err_cnt_d = last_err_cnt_q;
        err_d          = err_q;

        // Stage 2: fold the flags captured on the previous accepted beat into the counters.
        if (pipe_valid_q) begin
            samp_err_cnt_d = sat_add(samp_err_cnt_q, popcnt(mism_q));
            last_err_cnt_d = sat_add(last_err_cnt_q, 16'(last_bad_q));
            frame_cnt_d    = frame_cnt_q + 16'(frame_end_q);
            err_d          = err_q | (|mism_q) | last_bad_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    state_d        = RUN;
                    beat_d         = '0;
                    frames_d       = '0;
                    frame_cnt_d    = '0;
                    samp_err_cnt_d = '0;
                    last_err_cnt_d = '0;
                    err_d          = 1'b0;
                end
            end
            RUN: begin
                if (xfer) begin
                    pipe_valid_d = 1'b1;
                    mism_d       = lane_mism;
                    last_bad_d   = s_axis_tlast ^ exp_last;
                    frame_end_d  = s_axis_tlast | exp_last;
                    // Either an expected or an early tlast closes the frame and resyncs.
                    if (s_axis_tlast | exp_last) begin
                        beat_d   = '0;
                        frames_d = frames_q + FR_W'(1);
                        if (frames_q == FR_W'(NUM_FRAMES - 1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            frames_q       <= '0;
            pipe_valid_q   <= 1'b0;
            mism_q         <= '0;
            last_bad_q     <= 1'b0;
            frame_end_q    <= 1'b0;
            frame_cnt_q    <= '0;
            samp_err_cnt_q <= '0;
            last_err_cnt_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            frames_q       <= frames_d;
            pipe_valid_q   <= pipe_valid_d;
            mism_q         <= mism_d;
            last_bad_q     <= last_bad_d;
            frame_end_q    <= frame_end_d;
            frame_cnt_q    <= frame_cnt_d;
            samp_err_cnt_q <= samp_err_cnt_d;
            last_err_cnt_q <= last_err_cnt_d;
            err_q          <= err_d;
        end
    end

    assign s_axis_tready = tready;
    assign busy          = run | pipe_valid_q;
    assign done          = (state_q == DONE) & ~pipe_valid_q;
    assign err           = err_q;
    assign frame_cnt     = frame_cnt_q;
    assign samp_err_cnt  = samp_err_cnt_q;
    assign last_err_cnt  = last_err_cnt_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker: instance A (ramp, throttled) is driven with
// random frame streams and checked by a scoreboard; instance B (impulse,
// long run) covers impulse checking and counter saturation.
module tb_axis_frame_checker;
    import alpaca_types_streaming_packed_pkg::*;

    localparam int SPC   = SAMP_PER_CLK;
    localparam int FLEN  = 16;
    localparam int FB    = FLEN / SPC;
    localparam int A_NF  = 4;
    localparam int A_RP  = 3;
    localparam int B_NF  = 5000;
    localparam int B_PHA = 3;
    localparam int B_VAL = 16;

    typedef struct {
        int frames;
        int samp;
        int last;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     a_rst = 1'b0, a_en = 1'b0, a_tvalid = 1'b0, a_tlast = 1'b0;
    logic [SPC*2*WIDTH-1:0]   a_tdata = '0;
    logic                     a_tready, a_busy, a_done, a_err;
    logic [15:0]              a_frame_cnt, a_samp_err_cnt, a_last_err_cnt;

    logic                     b_rst = 1'b0, b_en = 1'b0, b_tvalid = 1'b0, b_tlast = 1'b0;
    logic [SPC*2*WIDTH-1:0]   b_tdata = '0;
    logic                     b_tready, b_busy, b_done, b_err;
    logic [15:0]              b_frame_cnt, b_samp_err_cnt, b_last_err_cnt;

    axis_frame_checker #(
        .FFT_LEN(FLEN), .CHECK_MODE(RAMP), .IMPULSE_PHA(0), .IMPULSE_VAL(1),
        .NUM_FRAMES(A_NF), .READY_PERIOD(A_RP)
    ) u_dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .s_axis_tdata(a_tdata),
        .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready), .s_axis_tlast(a_tlast),
        .busy(a_busy), .done(a_done), .err(a_err), .frame_cnt(a_frame_cnt),
        .samp_err_cnt(a_samp_err_cnt), .last_err_cnt(a_last_err_cnt)
    );

    axis_frame_checker #(
        .FFT_LEN(FLEN), .CHECK_MODE(IMPULSE), .IMPULSE_PHA(B_PHA), .IMPULSE_VAL(B_VAL),
        .NUM_FRAMES(B_NF), .READY_PERIOD(0)
    ) u_dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .s_axis_tdata(b_tdata),
        .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tlast(b_tlast),
        .busy(b_busy), .done(b_done), .err(b_err), .frame_cnt(b_frame_cnt),
        .samp_err_cnt(b_samp_err_cnt), .last_err_cnt(b_last_err_cnt)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    // Reference model state for instance A (reset at each run start).
    int m_beat, m_frames, m_samp, m_last;
    bit m_err, m_done;
    bit a_abort   = 0;
    bit a_in_run  = 0;
    int a_run_cyc = 0;
    bit tp_en     = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Apply one accepted beat to the model and queue the counters it implies.
    task automatic model_xfer(input pkt_stream_packed_t d, input logic last);
        int errs = 0;
        bit el;
        for (int j = 0; j < SPC; j++) begin
            if (d[j].re != 16'(m_beat * SPC + j) || d[j].im != 16'sd0) errs++;
        end
        el       = (m_beat == FB - 1);
        m_samp   = sat16(m_samp + errs);
        if (last != el) m_last = sat16(m_last + 1);
        m_err    = m_err | (errs > 0) | (last != el);
        if (el || last) begin
            m_frames++;
            m_beat = 0;
            if (m_frames == A_NF) m_done = 1;
        end else begin
            m_beat++;
        end
        exp_q.push_back('{m_frames, m_samp, m_last, m_err});
    endtask

    // Offer one beat to A and hold it until accepted (bounded wait).
    task automatic a_send(input pkt_stream_packed_t d, input logic last);
        int waited = 0;
        bit got = 0;
        a_tdata = d; a_tlast = last; a_tvalid = 1'b1;
        while (!got) begin
            @(negedge clk);
            if (a_tready) begin
                got = 1;
                model_xfer(d, last);
            end
            @(posedge clk); #1;
            waited++;
            if (!got && waited > 50) begin
                chk("a_accept_timeout", 32'd0, 32'd1);
                a_abort = 1;
                break;
            end
        end
        a_tvalid = 1'b0;
        if (m_done) a_in_run = 0;
    endtask

    task automatic a_start();
        a_en = 1'b1;
        @(posedge clk); #1;
        a_en = 1'b0;
        a_in_run = 1; a_run_cyc = 0;
        m_beat = 0; m_frames = 0; m_samp = 0; m_last = 0; m_err = 0; m_done = 0;
    endtask

    // scheme 0: clean ramp; 1: tlast on beat 0; 2: random corruption and gaps.
    task automatic a_run_frames(input int scheme, input int max_beats);
        int sent = 0;
        int sb = 0;
        int li;
        pkt_stream_packed_t pkt;
        logic last;
        while (!m_done && !a_abort && (max_beats < 0 || sent < max_beats)) begin
            for (int j = 0; j < SPC; j++) begin
                pkt[j].re = 16'(sb * SPC + j);
                pkt[j].im = '0;
            end
            last = (scheme == 1) ? (sb == 0) : (sb == FB - 1);
            if (scheme == 2) begin
                li = $urandom_range(SPC - 1);
                if ($urandom_range(5) == 0) pkt[li].re = pkt[li].re ^ 16'sh0100;
                li = $urandom_range(SPC - 1);
                if ($urandom_range(9) == 0) pkt[li].im = 16'sd1;
                if ($urandom_range(9) == 0) last = ~last;
            end
            if (scheme != 0 && $urandom_range(3) == 0) begin
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            a_send(pkt, last);
            sent++;
            sb = (sb == FB - 1) ? 0 : sb + 1;
        end
    endtask

    task automatic a_end_run();
        @(negedge clk);
        chk("a_done_low_pipe", a_done, 1'b0);
        chk("a_busy_pipe", a_busy, 1'b1);
        @(negedge clk);
        chk("a_done", a_done, 1'b1);
        chk("a_busy_idle", a_busy, 1'b0);
        chk("a_tready_done", a_tready, 1'b0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: counters for a beat accepted at negedge N are due at N+2.
    initial begin
        bit xf1 = 0, xf2 = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (xf2) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_underflow: got result with empty expected queue");
                end else begin
                    e = exp_q.pop_front();
                    if (a_frame_cnt == 16'(e.frames) && a_samp_err_cnt == 16'(e.samp) &&
                        a_last_err_cnt == 16'(e.last) && a_err == e.err) begin
                        n_pass++;
                    end else begin
                        $display("FAIL scoreboard: got frames=%0d samp=%0d last=%0d err=%0b expected frames=%0d samp=%0d last=%0d err=%0b",
                                 a_frame_cnt, a_samp_err_cnt, a_last_err_cnt, a_err,
                                 e.frames, e.samp, e.last, e.err);
                    end
                end
            end
            xf2 = xf1;
            xf1 = a_tvalid & a_tready & a_rst;
        end
    end

    // Throttle checker: in RUN tready follows 1,1,0,...; outside RUN it stays low.
    initial begin
        bit exp_r;
        forever begin
            @(negedge clk);
            if (tp_en) begin
                exp_r = 0;
                if (a_in_run) begin
                    exp_r = (a_run_cyc % A_RP) != (A_RP - 1);
                    a_run_cyc++;
                end
                chk("a_tready_pattern", a_tready, exp_r);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        pkt_stream_packed_t pkt;
        int b_stall = 0;
        int b_frames = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_done", a_done, 1'b0);
        chk("rst_a_err", a_err, 1'b0);
        chk("rst_a_frame_cnt", a_frame_cnt, 16'd0);
        chk("rst_b_tready", b_tready, 1'b0);
        chk("rst_b_counts", {b_samp_err_cnt, b_last_err_cnt}, 32'd0);
        @(posedge clk); #1;
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Clean ramp under throttling, then early tlast, then random faults.
        a_start(); a_run_frames(0, -1); a_end_run();
        a_start(); a_run_frames(1, -1); a_end_run();
        a_start(); a_run_frames(2, -1); a_end_run();

        // Reset in the middle of frame 1, then a fresh clean run.
        a_start(); a_run_frames(0, FB + 3);
        repeat (3) begin @(posedge clk); #1; end
        tp_en = 0; a_in_run = 0; a_rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        a_rst = 1'b1; tp_en = 1;
        @(negedge clk);
        chk("midrst_frame_cnt", a_frame_cnt, 16'd0);
        chk("midrst_samp_err", a_samp_err_cnt, 16'd0);
        chk("midrst_busy_done_err", {a_busy, a_done, a_err}, 3'b000);
        @(posedge clk); #1;
        a_start(); a_run_frames(0, -1); a_end_run();
        chk("a_final_err_clean", a_err, 1'b0);

        // Instance B: impulse frames, one corrupted frame, then an all-wrong flood.
        b_en = 1'b1; @(posedge clk); #1; b_en = 1'b0;
        for (int f = 0; f < B_NF; f++) begin
            if (f == 3 || f == 4) begin
                b_tvalid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                @(negedge clk);
                chk("b_frame_cnt_pause", b_frame_cnt, 16'(b_frames));
                chk("b_samp_err_pause", b_samp_err_cnt, (f == 3) ? 16'd0 : 16'd1);
                chk("b_last_err_pause", b_last_err_cnt, 16'd0);
                @(posedge clk); #1;
            end
            for (int bb = 0; bb < FB; bb++) begin
                for (int j = 0; j < SPC; j++) begin
                    pkt[j].re = (bb * SPC + j == B_PHA) ? 16'(B_VAL) : 16'sd0;
                    pkt[j].im = '0;
                    if (f >= 4) pkt[j].re = 16'sd5;
                end
                if (f == 3 && bb == 2) pkt[1].im = 16'sd1;
                b_tdata = pkt; b_tlast = (bb == FB - 1); b_tvalid = 1'b1;
                @(negedge clk);
                if (!b_tready) b_stall++;
                @(posedge clk); #1;
            end
            b_frames++;
        end
        b_tvalid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("b_ready_stalls", b_stall, 0);
        chk("b_frame_cnt_end", b_frame_cnt, 16'(B_NF));
        chk("b_samp_err_sat", b_samp_err_cnt, 16'hFFFF);
        chk("b_last_err_end", b_last_err_cnt, 16'd0);
        chk("b_done_err", {b_done, b_err, b_busy}, 3'b110);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
